// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: sizes, segment
// patterns (gfedcba, active-low) and the conversion FSM state type.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 13;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Non-decimal nibbles cannot come out of the converter; show them dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle,
// BIN_W iterations per conversion. done flags the cycle of the last iteration.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] bin;
  logic [3:0]       iter;
  logic             run;
  logic [BCD_W-1:0] bcd_adj;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = run && (iter == 4'(BIN_W - 1));

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin  <= '0;
      bcd  <= '0;
      iter <= '0;
      run  <= 1'b0;
    end else if (start) begin
      bin  <= value;
      bcd  <= '0;
      iter <= '0;
      run  <= 1'b1;
    end else if (run) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
      iter       <= iter + 4'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Converts the 13-bit debug word to BCD and time-multiplexes the four digits
// onto a common-anode seven-segment display with optional leading-zero blanking.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      value,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  conv_state_t      state, state_next;
  logic [BIN_W-1:0] value_q, last_val, cap_val;
  logic [BCD_W-1:0] disp, bcd;
  logic             start, commit, done;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value_q),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value_q != last_val) state_next = SHIFT;
      SHIFT:   if (done) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start  = (state == IDLE) && (value_q != last_val);
    commit = (state == COMMIT);
  end

  // The display register only changes on commit, so a half-shifted
  // accumulator is never visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q  <= '0;
      last_val <= '0;
      cap_val  <= '0;
      disp     <= '0;
      busy     <= 1'b0;
    end else begin
      value_q <= value;
      busy    <= (state_next != IDLE);
      if (start) cap_val <= value_q;
      if (commit) begin
        disp     <= bcd;
        last_val <= cap_val;
      end
    end
  end

  logic [CNT_W-1:0]      scan_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [3:0]            digit;
  logic                  blank;
  logic [NUM_DIGITS-1:0] anode_next;
  logic [6:0]            seg_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 1'b1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // lead_zero[d]: digit d and every digit above it are zero. Digit 0 never blanks.
  always_comb begin
    lead_zero                 = '0;
    lead_zero[NUM_DIGITS-1]   = (disp[BCD_W-1 -: 4] == 4'd0);
    for (int d = NUM_DIGITS - 2; d > 0; d--) begin
      lead_zero[d] = lead_zero[d+1] && (disp[4*d +: 4] == 4'd0);
    end
  end

  always_comb begin
    digit      = disp[{digit_idx, 2'b00} +: 4];
    blank      = BLANK_LZ && lead_zero[digit_idx];
    anode_next = blank ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
    seg_next   = blank ? SEG_BLANK : seg_decode(digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode <= '1;
      seg   <= SEG_BLANK;
    end else begin
      anode <= anode_next;
      seg   <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with REFRESH_DIV=4; a second instance
// with BLANK_LZ=0 shares the inputs to cover the unblanked display.
module tb_ssd_scan_driver;
  import ssd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] value = '0;
  logic [3:0]  anode, anode2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2, busy, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value),
    .anode(anode), .seg(seg), .dp(dp), .busy(busy)
  );

  ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .value(value),
    .anode(anode2), .seg(seg2), .dp(dp2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Edges since reset release; slot shown after edge n is ((n-1)/4)%4.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic int slot_now();
    return ((cyc - 1) / 4) % 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic wait_slot(input int d);
    int k;
    k = 0;
    @(negedge clk);
    while ((cyc < 1 || slot_now() != d) && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_digit(input string tag, input int d,
                             input logic [3:0] exp_an, input logic [6:0] exp_seg);
    wait_slot(d);
    check({tag, " anode"}, 32'(anode), 32'(exp_an));
    check({tag, " seg"},   32'(seg),   32'(exp_seg));
  endtask

  task automatic measure_busy(output int lat, output int width);
    lat   = -1;
    width = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) begin
        if (lat < 0) lat = i;
        width++;
      end else if (lat >= 0) begin
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed no end, expected end");
    $fatal(1);
  end

  initial begin
    int lat, width, seen5, pulses, w0, w1;
    logic prev_busy;
    logic [12:0] exp_slot;

    // Reset state
    #12;
    check("rst anode", 32'(anode), 32'(4'b1111));
    check("rst seg",   32'(seg),   32'(7'b1111111));
    check("rst dp",    32'(dp),    32'(1'b1));
    check("rst busy",  32'(busy),  32'(1'b0));

    // Release with value=0: digit 0 shows '0', slots 1..3 dark, busy idle
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_slot = (slot_now() == 0) ? {4'b1110, 7'b1000000, 1'b1, 1'b0}
                                   : {4'b1111, 7'b1111111, 1'b1, 1'b0};
      check("zero scan", 32'({anode, seg, dp, busy}), 32'(exp_slot));
    end

    // 1234
    value = 13'd1234;
    measure_busy(lat, width);
    check("1234 busy latency", 32'(lat), 32'd2);
    check("1234 busy width",   32'(width), 32'd14);
    check_digit("1234 d0", 0, 4'b1110, 7'b0011001);
    check_digit("1234 d1", 1, 4'b1101, 7'b0110000);
    check_digit("1234 d2", 2, 4'b1011, 7'b0100100);
    check_digit("1234 d3", 3, 4'b0111, 7'b1111001);

    // 8191, maximum input
    value = 13'd8191;
    measure_busy(lat, width);
    check("8191 busy width", 32'(width), 32'd14);
    check_digit("8191 d0", 0, 4'b1110, 7'b1111001);
    check_digit("8191 d1", 1, 4'b1101, 7'b0010000);
    check_digit("8191 d2", 2, 4'b1011, 7'b1111001);
    check_digit("8191 d3", 3, 4'b0111, 7'b0000000);

    // 100: leading-zero blank on digit 3 only; unblanked instance shows '0'
    value = 13'd100;
    measure_busy(lat, width);
    check("100 busy width", 32'(width), 32'd14);
    check_digit("100 d0", 0, 4'b1110, 7'b1000000);
    check_digit("100 d1", 1, 4'b1101, 7'b1000000);
    check_digit("100 d2", 2, 4'b1011, 7'b1111001);
    check_digit("100 d3", 3, 4'b1111, 7'b1111111);
    check("100 nolz d3 anode", 32'(anode2), 32'(4'b0111));
    check("100 nolz d3 seg",   32'(seg2),   32'(7'b1000000));

    // 5 then 7 mid-SHIFT: two full busy pulses, 5 shown between them, ends on 7
    value = 13'd5;
    seen5 = 0; pulses = 0; w0 = 0; w1 = 0; prev_busy = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) pulses++;
      if (busy && pulses == 1) w0++;
      if (busy && pulses == 2) w1++;
      if (anode == 4'b1110 && seg == SEG_5) seen5 = 1;
      prev_busy = busy;
      if (i == 5) value = 13'd7;
    end
    check("5/7 pulse count",   32'(pulses), 32'd2);
    check("5/7 first width",   32'(w0), 32'd14);
    check("5/7 second width",  32'(w1), 32'd14);
    check("5/7 five shown",    32'(seen5), 32'd1);
    check_digit("7 d0", 0, 4'b1110, 7'b1111000);
    check_digit("7 d1", 1, 4'b1111, 7'b1111111);

    // Reset mid-SHIFT with 4321: asynchronous clear, then reconversion
    value = 13'd4321;
    repeat (6) @(negedge clk);
    check("pre-abort busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort anode", 32'(anode), 32'(4'b1111));
    check("abort seg",   32'(seg),   32'(7'b1111111));
    check("abort busy",  32'(busy),  32'(1'b0));
    check("abort dp",    32'(dp),    32'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    measure_busy(lat, width);
    check("4321 busy latency", 32'(lat), 32'd2);
    check("4321 busy width",   32'(width), 32'd14);
    check_digit("4321 d0", 0, 4'b1110, 7'b1111001);
    check_digit("4321 d1", 1, 4'b1101, 7'b0100100);
    check_digit("4321 d2", 2, 4'b1011, 7'b0110000);
    check_digit("4321 d3", 3, 4'b0111, 7'b0011001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Display-side consumer of the 13-bit `ssd` debug word that the core top level drives for board bring-up.
- Converts the binary word to 4 BCD digits using a sequential double-dabble engine.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits at board top, between the core's `ssd` output and the FPGA pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is lit (1 ms at 100 MHz); minimum 2.
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = show all four digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- value  in  13  binary word to display, 0..8191; sampled continuously.
- anode  out  4  digit enables, active-low; anode[0] = least-significant digit.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low; always 1 (off).
- busy  out  1  1 while a conversion is in progress.

Behaviour:
- Reset (rst=0), applied asynchronously:
  - anode=4'b1111, seg=7'b1111111, dp=1, busy=0.
  - display BCD register=0, last_val=0, scan counter=0, digit index=0, FSM=IDLE.
- Conversion FSM with states IDLE, SHIFT, COMMIT:
  - IDLE, when value != last_val: capture value, clear the 16-bit BCD accumulator, iteration count=0. Go to SHIFT and set busy=1 on the next edge.
  - SHIFT, 13 cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left 1. After iteration 12, go to COMMIT.
  - COMMIT, 1 cycle: copy the accumulator to the display register, last_val = captured value, busy=0, go to IDLE.
  - Latency: value first sampled different at edge T → display register updated at edge T+15.
- Value changes during SHIFT/COMMIT do not affect the conversion in flight. IDLE re-compares on the following cycle and starts a new conversion if value differs. The display never shows a partial result.
- Reset mid-conversion aborts it; the display returns to 0.
- Scan:
  - Counter runs 0..REFRESH_DIV-1. On wrap, the digit index increments 0→1→2→3→0.
  - Outputs are registered and reflect the current index and display register one cycle later.
  - First edge after reset release: anode=4'b1110 with the digit-0 pattern.
- Decode, digits 0..9 (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles above 9 cannot occur; decode them as blank (1111111).
- Blanking (BLANK_LZ=1): digit d>0 is blank when it and all higher digits are 0. A blank digit drives anode=4'b1111 and seg=7'b1111111 for its slot. Digit 0 is never blanked.
- The scan is independent of conversion; both proceed concurrently.

Decomposition:
- Shared package `ssd_pkg` holds:
  - NUM_DIGITS=4 and BIN_W=13.
  - The 10-entry seven-segment pattern constants and SEG_BLANK.
  - The FSM state typedef (IDLE/SHIFT/COMMIT).
- Sub-module `bin2bcd_seq`: the double-dabble engine with start/value in and done/bcd[15:0] out, holding the SHIFT iteration counter.
- The top holds change detection, the display register, the scan counter, the blanking logic and the output registers.

Test Plan:
All scenarios use REFRESH_DIV=4.
- Reset release with value=0 → anode=1110, seg=1000000 for 4 cycles. Slots 1–3 give anode=1111, seg=1111111. dp=1 throughout. busy stays 0.
- value=1234 → busy=1 for 14 cycles; display register updated 15 cycles after the change. Digits 0..3 show 4,3,2,1 (0011001, 0110000, 0100100, 1111001).
- value=8191 (max) → digits 1,9,1,8 on digits 0..3 (1111001, 0010000, 1111001, 0000000). No blanking.
- value=100 → digit3 blank (anode 1111), digit2 '1', digits 1 and 0 '0'. With BLANK_LZ=0, digit3 shows 1000000.
- value 5, then 7 five cycles later (mid-SHIFT) → first conversion commits 5, a second conversion starts, and the final display shows 7. busy has two pulses of 14 cycles each.
- rst=0 asserted mid-SHIFT with value=4321 → outputs go to reset values immediately (asynchronously). After release, value=4321 still differs from last_val=0, so it reconverts and shows 1,2,3,4 on digits 0..3.
